// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage: program counter, next-PC selection, instruction
//   memory request handshake, a one-entry hold buffer for a word that arrives
//   while decode is stalled, and the IF/ID pipeline register.
//
// Ports
//   Clk               rising-edge clock
//   Rst               synchronous reset, active low
//   PCWrite           0 = PC must not advance (hazard unit)
//   IFIDWrite         0 = IF/ID register holds (hazard unit)
//   PCSrc             00 sequential, 01 branch, 10 jump, 11 jr (non-zero = redirect)
//   BranchTarget      redirect address for PCSrc=01
//   JumpTarget        redirect address for PCSrc=10
//   JRTarget          redirect address for PCSrc=11
//   IMemReq           fetch request valid
//   IMemAddr          fetch address
//   IMemReady         IMemData valid for the outstanding request
//   IMemData          returned instruction word
//   IFID_Instruction  IF/ID instruction word
//   IFID_PCPlus4      IF/ID PC+4 of that instruction
//   IFID_Valid        1 = real instruction, 0 = bubble
//   PC                current PC (debug)
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] JumpTarget,
    input  logic [31:0] JRTarget,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [31:0] PC
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HOLD  = 2'b10
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic [31:0] buf_r, buf_s;
    logic [31:0] redir_pc_r, redir_pc_s;
    logic        drop_r, drop_s;
    logic [31:0] ifid_instr_r, ifid_instr_s;
    logic [31:0] ifid_pc4_r, ifid_pc4_s;
    logic        ifid_valid_r, ifid_valid_s;
    logic        imem_req_r;

    logic        redirect_s;
    logic [31:0] target_raw_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;

    // Redirect target select; targets are word aligned so the low bits are cleared.
    always_comb begin
        redirect_s = (PCSrc != 2'b00);
        case (PCSrc)
            2'b01:   target_raw_s = BranchTarget;
            2'b10:   target_raw_s = JumpTarget;
            2'b11:   target_raw_s = JRTarget;
            default: target_raw_s = 32'h0000_0000;
        endcase
        target_s   = {target_raw_s[31:2], 2'b00};
        pc_plus4_s = pc_r + 32'd4;   // wraps modulo 2^32
    end

    // Next-state, next-PC and IF/ID update logic.
    always_comb begin
        state_s      = state_r;
        pc_s         = pc_r;
        buf_s        = buf_r;
        redir_pc_s   = redir_pc_r;
        drop_s       = drop_r;
        ifid_instr_s = ifid_instr_r;
        ifid_pc4_s   = ifid_pc4_r;
        ifid_valid_s = ifid_valid_r;

        case (state_r)
            ST_BOOT: begin
                state_s = ST_FETCH;
            end

            ST_FETCH: begin
                if (IMemReady) begin
                    if (redirect_s) begin
                        // A redirect on the return cycle beats everything; the word is stale.
                        pc_s         = target_s;
                        drop_s       = 1'b0;
                        ifid_instr_s = NOP_INSTR;
                        ifid_valid_s = 1'b0;
                    end else if (drop_r) begin
                        // Word belongs to a path already abandoned; resume at the saved target.
                        pc_s   = redir_pc_r;
                        drop_s = 1'b0;
                        if (IFIDWrite) begin
                            ifid_instr_s = NOP_INSTR;
                            ifid_valid_s = 1'b0;
                        end else begin
                            ifid_valid_s = ifid_valid_r;
                        end
                    end else if (IFIDWrite) begin
                        ifid_instr_s = IMemData;
                        ifid_pc4_s   = pc_plus4_s;
                        ifid_valid_s = 1'b1;
                        if (PCWrite) begin
                            pc_s = pc_plus4_s;
                        end else begin
                            pc_s = pc_r;
                        end
                    end else begin
                        // Decode is stalled: park the word until IF/ID can take it.
                        buf_s   = IMemData;
                        state_s = ST_HOLD;
                    end
                end else begin
                    if (redirect_s) begin
                        // Request still in flight; keep the address stable and discard its data later.
                        redir_pc_s   = target_s;
                        drop_s       = 1'b1;
                        ifid_instr_s = NOP_INSTR;
                        ifid_valid_s = 1'b0;
                    end else if (IFIDWrite) begin
                        ifid_instr_s = NOP_INSTR;
                        ifid_valid_s = 1'b0;
                    end else begin
                        ifid_valid_s = ifid_valid_r;
                    end
                end
            end

            ST_HOLD: begin
                if (redirect_s) begin
                    pc_s         = target_s;
                    ifid_instr_s = NOP_INSTR;
                    ifid_valid_s = 1'b0;
                    state_s      = ST_FETCH;
                end else if (IFIDWrite) begin
                    ifid_instr_s = buf_r;
                    ifid_pc4_s   = pc_plus4_s;
                    ifid_valid_s = 1'b1;
                    state_s      = ST_FETCH;
                    if (PCWrite) begin
                        pc_s = pc_plus4_s;
                    end else begin
                        pc_s = pc_r;
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end

            default: begin
                state_s = ST_BOOT;
            end
        endcase
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_r      <= ST_BOOT;
            pc_r         <= RESET_PC;
            buf_r        <= 32'h0000_0000;
            redir_pc_r   <= 32'h0000_0000;
            drop_r       <= 1'b0;
            ifid_instr_r <= NOP_INSTR;
            ifid_pc4_r   <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
            imem_req_r   <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            buf_r        <= buf_s;
            redir_pc_r   <= redir_pc_s;
            drop_r       <= drop_s;
            ifid_instr_r <= ifid_instr_s;
            ifid_pc4_r   <= ifid_pc4_s;
            ifid_valid_r <= ifid_valid_s;
            // Request is raised exactly while the machine sits in FETCH.
            imem_req_r   <= (state_s == ST_FETCH);
        end
    end

    assign IMemReq          = imem_req_r;
    assign IMemAddr         = pc_r;
    assign IFID_Instruction = ifid_instr_r;
    assign IFID_PCPlus4     = ifid_pc4_r;
    assign IFID_Valid       = ifid_valid_r;
    assign PC               = pc_r;

endmodule
